// File: rtl/rf_port_arbiter_if.sv
// Requester-side bundle for rf_port_arbiter: two request/response ports packed per-port.
// master = requesters (datapath + debug/loader), slave = arbiter.
interface rf_port_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_ready;
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [DW-1:0]   resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// Two-port arbiter in front of a 1R/1W register file: fixed priority to port 0 with a
// starvation limit for port 1, one transaction in flight (IDLE -> ACCESS -> RESP).
module rf_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 5,
  parameter int DW           = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_port_arbiter_if.slave     bus,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic [AW-1:0]        rf_raddr,
  input  logic [DW-1:0]        rf_rdata,
  output logic [1:0]           dbg_state,
  output logic [3:0]           dbg_starve
);

  // Handshakes: a request transfers on a posedge where req_valid[i] & req_ready[i];
  // a response transfers on a posedge where resp_valid[i] & resp_ready[i].
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [1:0]      grant;
  logic            force_p1;
  logic            owner;
  logic            we_q;
  logic [3:0]      starve_cnt;
  logic [DW-1:0]   resp_rdata_q;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // Port 1 wins only once port 0 has taken STARVE_LIMIT contended grants in a row.
  always_comb begin
    grant    = 2'b00;
    force_p1 = bus.req_valid[1] && (starve_cnt == 4'(STARVE_LIMIT));
    if (bus.req_valid[0] && !force_p1) begin
      grant = 2'b01;
    end else if (bus.req_valid[1]) begin
      grant = 2'b10;
    end
  end

  always_comb begin
    sel_we    = grant[1] ? bus.req_we[1]          : bus.req_we[0];
    sel_addr  = grant[1] ? bus.req_addr[AW +: AW] : bus.req_addr[0 +: AW];
    sel_wdata = grant[1] ? bus.req_wdata[DW +: DW] : bus.req_wdata[0 +: DW];
  end

  always_comb begin
    state_n        = state;
    bus.req_ready  = 2'b00;
    bus.resp_valid = 2'b00;
    case (state)
      IDLE: begin
        if (!rst) begin
          bus.req_ready = grant;
          if (grant != 2'b00) state_n = ACCESS;
        end
      end
      ACCESS: state_n = RESP;
      RESP: begin
        if (!rst) bus.resp_valid[owner] = 1'b1;
        if (bus.resp_ready[owner]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      we_q         <= 1'b0;
      starve_cnt   <= 4'd0;
      resp_rdata_q <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      rf_raddr     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            owner    <= grant[1];
            we_q     <= sel_we;
            rf_raddr <= sel_addr;
            // Writes to register 0 still complete and respond, but never reach the RF.
            if (sel_we && (sel_addr != '0)) begin
              rf_we    <= 1'b1;
              rf_waddr <= sel_addr;
              rf_wdata <= sel_wdata;
            end
            if (grant[1]) begin
              starve_cnt <= 4'd0;
            end else if (bus.req_valid[1] && (starve_cnt != 4'(STARVE_LIMIT))) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ACCESS: begin
          resp_rdata_q <= we_q ? '0 : rf_rdata;
          rf_we        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = resp_rdata_q;
  assign dbg_state      = state;
  assign dbg_starve     = starve_cnt;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural RF that commits on negedge.
module tb_rf_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_starve;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rf_mem [32];

  rf_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  rf_port_arbiter #(.STARVE_LIMIT(4), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .dbg_state  (dbg_state),
    .dbg_starve (dbg_starve)
  );

  // clock / RF model
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
  end

  always @(negedge clk) begin
    if (rf_we && (rf_waddr != '0)) rf_mem[rf_waddr] <= rf_wdata;
  end

  assign rf_rdata = (rf_raddr == '0) ? '0 : rf_mem[rf_raddr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction on port p, expected response data taken from the scoreboard.
  task automatic xact(input int p, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    int n;
    logic [DW-1:0] e;
    logic exp_we;
    exp_we = we && (a != '0);
    bus.req_we[p]            = we;
    bus.req_addr[p*AW +: AW] = a;
    bus.req_wdata[p*DW +: DW] = wd;
    bus.req_valid[p]         = 1'b1;
    exp_q.push_back(exp_rd);
    #1;
    n = 0;
    while (!bus.req_ready[p] && n < 20) begin
      tick();
      n++;
    end
    check("grant", 32'(bus.req_ready), 32'd1 << p);
    tick();
    bus.req_valid[p] = 1'b0;
    #1;
    check("acc_state", 32'(dbg_state), 32'd1);
    check("acc_rf_we", 32'(rf_we), 32'(exp_we));
    check("acc_raddr", 32'(rf_raddr), 32'(a));
    check("acc_ready", 32'(bus.req_ready), 32'd0);
    if (exp_we) begin
      check("acc_waddr", 32'(rf_waddr), 32'(a));
      check("acc_wdata", rf_wdata, wd);
    end
    tick();
    e = exp_q.pop_front();
    check("resp_rf_we", 32'(rf_we), 32'd0);
    check("resp_valid", 32'(bus.resp_valid), 32'd1 << p);
    check("resp_rdata", bus.resp_rdata, e);
    bus.resp_ready[p] = 1'b1;
    tick();
    bus.resp_ready[p] = 1'b0;
    #1;
    check("idle_valid", 32'(bus.resp_valid), 32'd0);
    check("idle_state", 32'(dbg_state), 32'd0);
  endtask

  logic [1:0] g_exp [10];
  int n;

  initial begin
    g_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    bus.req_valid  = 2'b11;
    bus.req_we     = 2'b00;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 2'b00;

    // reset with both ports requesting
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    end
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_starve", 32'(dbg_starve), 32'd0);
    bus.req_valid = 2'b00;
    rst = 1'b0;
    tick();

    // write r5 from port 0, read back from port 1
    xact(0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0);
    xact(1, 1'b0, 5'd5, 32'h0, 32'hDEADBEEF);

    // write to r0 is dropped but still answered
    xact(0, 1'b1, 5'd0, 32'h1234, 32'h0);
    xact(0, 1'b0, 5'd0, 32'h0, 32'h0);

    // starvation limit under continuous contention
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_we     = 2'b00;
    bus.req_addr   = {5'd5, 5'd5};
    bus.resp_ready = 2'b11;
    bus.req_valid  = 2'b11;
    #1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (bus.req_ready == 2'b00 && n < 20) begin
        tick();
        n++;
      end
      check("arb_grant", 32'(bus.req_ready), 32'(g_exp[i]));
      tick();
      tick();
      check("arb_resp", 32'(bus.resp_valid), 32'(g_exp[i]));
      check("arb_rdata", bus.resp_rdata, 32'hDEADBEEF);
      tick();
    end
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
    #1;

    // response back-pressure on port 1 blocks port 0
    bus.req_we[1]       = 1'b0;
    bus.req_addr[AW +: AW] = 5'd5;
    bus.req_valid[1]    = 1'b1;
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'd2);
    tick();
    bus.req_valid[1]    = 1'b0;
    bus.req_we[0]       = 1'b0;
    bus.req_addr[0 +: AW] = 5'd9;
    bus.req_valid[0]    = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.resp_valid), 32'd2);
      check("bp_rdata", bus.resp_rdata, 32'hDEADBEEF);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.resp_ready[1] = 1'b1;
    tick();
    bus.resp_ready[1] = 1'b0;
    #1;
    check("bp_release", 32'(bus.req_ready), 32'd1);
    bus.req_valid[0] = 1'b0;
    #1;

    // reset during a write access
    bus.req_we        = 2'b01;
    bus.req_addr      = {5'd3, 5'd7};
    bus.req_wdata     = {32'h0, 32'hCAFE};
    bus.req_valid     = 2'b11;
    #1;
    check("ab_grant", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("ab_rf_we", 32'(rf_we), 32'd1);
    check("ab_starve", 32'(dbg_starve), 32'd1);
    rst = 1'b1;
    tick();
    check("ab_rf_we_off", 32'(rf_we), 32'd0);
    check("ab_state", 32'(dbg_state), 32'd0);
    check("ab_starve_clr", 32'(dbg_starve), 32'd0);
    check("ab_resp", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("ab_resp_after", 32'(bus.resp_valid), 32'd0);
    check("ab_state_after", 32'(dbg_state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
